// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit PWM driver for a discrete RGB LED.
// Colour is double-buffered per channel and only taken at frame wrap.

module rgb_pwm_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       load,
  input  logic [7:0] duty_in,
  input  logic [7:0] pwm_cnt,
  output logic       led
);
  logic [7:0] sh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh  <= 8'd0;
      led <= 1'b0;
    end else begin
      if (load) sh <= duty_in;
      led <= enable && (pwm_cnt < sh);
    end
  end
endmodule

module rgb_pwm_driver #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] light,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b,
  output logic        frame_start
);
  localparam int NUM_LANES = 3;
  localparam int VEC_W     = 8;
  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [15:0] pre_cnt;
  logic [VEC_W-1:0] pwm_cnt;
  logic step, wrap, load;
  logic [NUM_LANES-1:0][VEC_W-1:0] duty;
  logic [NUM_LANES-1:0] led_vec;

  assign step = (pre_cnt == PRE_MAX);
  assign wrap = step && (pwm_cnt == 8'hFF);
  // While disabled the shadows track light, so re-enable starts with the latest colour.
  assign load = !enable || wrap;
  assign duty = light;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt     <= 16'd0;
      pwm_cnt     <= 8'd0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      pre_cnt     <= 16'd0;
      pwm_cnt     <= 8'd0;
      frame_start <= 1'b0;
    end else begin
      pre_cnt     <= step ? 16'd0 : pre_cnt + 16'd1;
      if (step) pwm_cnt <= pwm_cnt + 8'd1;
      frame_start <= (pwm_cnt == 8'd0) && (pre_cnt == 16'd0);
    end
  end

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      rgb_pwm_lane u_lane (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .load    (load),
        .duty_in (duty[i]),
        .pwm_cnt (pwm_cnt),
        .led     (led_vec[i])
      );
    end
  endgenerate

  assign led_r = led_vec[2];
  assign led_g = led_vec[1];
  assign led_b = led_vec[0];
endmodule
